// File: rtl/cheshire_pkg.sv
// ============================================================================
// Module : cheshire_pkg
// Brief  : Shared Regbus types and Regbus arbiter constants.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package cheshire_pkg;

  typedef struct packed {
    logic [47:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        valid;
  } reg_a48_d32_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        error;
    logic        ready;
  } reg_a48_d32_rsp_t;

  typedef enum int unsigned {
    RegbusArbInXbar,
    RegbusArbInDbg,
    RegbusArbNumInputs
  } regbus_arb_inputs_e;

  localparam int unsigned RegbusArbTimeout = 1024;

endpackage

`default_nettype wire

// File: rtl/cheshire_rr_picker.sv
// ============================================================================
// Module : cheshire_rr_picker
// Brief  : First set bit of a valid vector, scanning circularly from a pointer.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module cheshire_rr_picker #(
  parameter int unsigned NumReq = 2
) (
  input  logic [NumReq-1:0]         valid_i,
  input  logic [$clog2(NumReq)-1:0] ptr_i,
  output logic [$clog2(NumReq)-1:0] idx_o,
  output logic                      any_o
);

  localparam int unsigned IdxW = $clog2(NumReq);

  always_comb begin
    int j;
    idx_o = '0;
    any_o = 1'b0;
    for (int k = 0; k < int'(NumReq); k++) begin
      j = int'(ptr_i) + k;
      if (j >= int'(NumReq)) j = j - int'(NumReq);
      if (!any_o && valid_i[j]) begin
        idx_o = IdxW'(j);
        any_o = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/cheshire_regbus_arbiter.sv
// ============================================================================
// Module : cheshire_regbus_arbiter
// Brief  : Round-robin Regbus arbiter with locked grant and abort watchdog.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module cheshire_regbus_arbiter
  import cheshire_pkg::*;
#(
  parameter int unsigned NumReq        = 2,
  parameter int unsigned TimeoutCycles = RegbusArbTimeout,
  parameter logic [31:0] ErrData       = 32'hBADCAB1E
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  reg_a48_d32_req_t [NumReq-1:0]     slv_req_i,
  output reg_a48_d32_rsp_t [NumReq-1:0]     slv_rsp_o,
  output reg_a48_d32_req_t                  mst_req_o,
  input  reg_a48_d32_rsp_t                  mst_rsp_i,
  output logic                              busy_o,
  output logic [$clog2(NumReq)-1:0]         owner_o,
  output logic                              timeout_o
);

  localparam int unsigned IdxW = $clog2(NumReq);
  localparam int unsigned CntW = (TimeoutCycles == 0) ? 1 : $clog2(TimeoutCycles + 1);
  localparam logic [CntW-1:0] CntLast =
      CntW'((TimeoutCycles == 0) ? 0 : TimeoutCycles - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BUSY  = 2'd1;
  localparam logic [1:0] ST_ABORT = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [IdxW-1:0] owner_q, owner_d;
  logic [IdxW-1:0] rr_ptr_q, rr_ptr_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic [NumReq-1:0] req_valid;
  logic [IdxW-1:0]   pick_idx;
  logic              pick_any;
  logic [IdxW-1:0]   owner_next;
  logic              owner_valid;

  for (genvar i = 0; i < NumReq; i++) begin : g_valid
    assign req_valid[i] = slv_req_i[i].valid;
  end

  cheshire_rr_picker #(
    .NumReq (NumReq)
  ) i_picker (
    .valid_i (req_valid),
    .ptr_i   (rr_ptr_q),
    .idx_o   (pick_idx),
    .any_o   (pick_any)
  );

  assign owner_next  = (owner_q == IdxW'(NumReq - 1)) ? '0 : owner_q + 1'b1;
  assign owner_valid = slv_req_i[owner_q].valid;

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    cnt_d    = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          owner_d = pick_idx;
          cnt_d   = '0;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        // Completion and a dropped request both release the bus; completion beats timeout.
        if (!owner_valid || mst_rsp_i.ready) begin
          rr_ptr_d = owner_next;
          state_d  = ST_IDLE;
        end else if ((TimeoutCycles != 0) && (cnt_q == CntLast)) begin
          state_d = ST_ABORT;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_ABORT: begin
        rr_ptr_d = owner_next;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      owner_q  <= '0;
      rr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    mst_req_o = '0;
    slv_rsp_o = '0;
    timeout_o = 1'b0;
    case (state_q)
      ST_BUSY: begin
        mst_req_o          = slv_req_i[owner_q];
        slv_rsp_o[owner_q] = mst_rsp_i;
      end
      ST_ABORT: begin
        slv_rsp_o[owner_q].rdata = ErrData;
        slv_rsp_o[owner_q].error = 1'b1;
        slv_rsp_o[owner_q].ready = 1'b1;
        timeout_o                = 1'b1;
      end
      default: ;
    endcase
  end

  assign busy_o  = (state_q != ST_IDLE);
  assign owner_o = owner_q;

endmodule

`default_nettype wire

// File: tb/tb_cheshire_regbus_arbiter.sv
// ============================================================================
// Module : tb_cheshire_regbus_arbiter
// Brief  : Directed self-checking bench for the Regbus arbiter (4 ports, timeout 8).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_cheshire_regbus_arbiter;
  import cheshire_pkg::*;

  logic                   clk;
  logic                   rst;
  reg_a48_d32_req_t [3:0] slv_req;
  reg_a48_d32_rsp_t [3:0] slv_rsp;
  reg_a48_d32_req_t       mst_req;
  reg_a48_d32_rsp_t       mst_rsp;
  logic                   busy;
  logic [1:0]             owner;
  logic                   tout;

  int checks   = 0;
  int failures = 0;

  cheshire_regbus_arbiter #(
    .NumReq        (4),
    .TimeoutCycles (8),
    .ErrData       (32'hBADCAB1E)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .slv_req_i (slv_req),
    .slv_rsp_o (slv_rsp),
    .mst_req_o (mst_req),
    .mst_rsp_i (mst_rsp),
    .busy_o    (busy),
    .owner_o   (owner),
    .timeout_o (tout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [47:0] addr, input logic wr, input logic v);
    slv_req[i].addr  = addr;
    slv_req[i].write = wr;
    slv_req[i].wdata = 32'hDEADBEEF;
    slv_req[i].wstrb = 4'hF;
    slv_req[i].valid = v;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_tout"}, 64'(tout), 64'd0);
    check({tag, "_mst0"}, 64'(mst_req == '0), 64'd1);
    check({tag, "_rsp0"}, 64'(slv_rsp == '0), 64'd1);
  endtask

  initial begin
    rst     = 1'b1;
    slv_req = '0;
    mst_rsp = '0;
    step();
    step();
    check_quiet("reset");
    check("reset_owner", 64'(owner), 64'd0);

    // Single read: grant one cycle after valid, response in third BUSY cycle
    rst = 1'b0;
    set_req(0, 48'h02000000, 1'b0, 1'b1);
    #1;
    check("rd_no_comb_valid", 64'(mst_req.valid), 64'd0);
    step();
    check("rd_busy", 64'(busy), 64'd1);
    check("rd_owner", 64'(owner), 64'd0);
    check("rd_mst_valid", 64'(mst_req.valid), 64'd1);
    check("rd_mst_addr", 64'(mst_req.addr), 64'h02000000);
    check("rd_wait_ready", 64'(slv_rsp[0].ready), 64'd0);
    step();
    step();
    mst_rsp = '{rdata: 32'h12345678, error: 1'b0, ready: 1'b1};
    #1;
    check("rd_ready", 64'(slv_rsp[0].ready), 64'd1);
    check("rd_rdata", 64'(slv_rsp[0].rdata), 64'h12345678);
    check("rd_other_ready", 64'(slv_rsp[1].ready), 64'd0);
    step();
    check_quiet("rd_idle");

    // Contention between ports 0 and 1; pointer sits at 1 after the read
    set_req(0, 48'h100, 1'b0, 1'b1);
    set_req(1, 48'h200, 1'b1, 1'b1);
    mst_rsp = '{rdata: 32'hA5A5A5A5, error: 1'b0, ready: 1'b1};
    for (int k = 0; k < 4; k++) begin
      int e;
      e = (k % 2 == 0) ? 1 : 0;
      step();
      check("ct_owner", 64'(owner), 64'(e));
      check("ct_busy", 64'(busy), 64'd1);
      check("ct_addr", 64'(mst_req.addr), (e == 1) ? 64'h200 : 64'h100);
      check("ct_own_ready", 64'(slv_rsp[e].ready), 64'd1);
      check("ct_other_ready", 64'(slv_rsp[1-e].ready), 64'd0);
      step();
      check("ct_gap_busy", 64'(busy), 64'd0);
    end

    // Fairness: all four valid from reset
    rst = 1'b1;
    step();
    check_quiet("fair_reset");
    rst = 1'b0;
    for (int i = 0; i < 4; i++) set_req(i, 48'(i) << 12, 1'b0, 1'b1);
    for (int g = 0; g < 5; g++) begin
      step();
      check("fair_owner", 64'(owner), 64'(g % 4));
      check("fair_addr", 64'(mst_req.addr), 64'(g % 4) << 12);
      step();
      check("fair_gap_busy", 64'(busy), 64'd0);
    end
    slv_req = '0;
    mst_rsp = '0;

    // Timeout: demux never ready; pointer is 1 so port 2 is picked
    set_req(2, 48'h10000000, 1'b1, 1'b1);
    for (int b = 1; b <= 8; b++) begin
      step();
      check("to_busy", 64'(busy), 64'd1);
      check("to_owner", 64'(owner), 64'd2);
      check("to_no_pulse", 64'(tout), 64'd0);
      check("to_mst_valid", 64'(mst_req.valid), 64'd1);
    end
    step();
    check("ab_tout", 64'(tout), 64'd1);
    check("ab_busy", 64'(busy), 64'd1);
    check("ab_mst_valid", 64'(mst_req.valid), 64'd0);
    check("ab_rsp", 64'(slv_rsp[2]), 64'({32'hBADCAB1E, 1'b1, 1'b1}));
    check("ab_other_rsp", 64'(slv_rsp[0]), 64'd0);
    slv_req[2].valid = 1'b0;
    step();
    check_quiet("ab_after");

    // Reset mid-transaction; pointer is 3 so port 3 wins first
    set_req(0, 48'h4000, 1'b0, 1'b1);
    set_req(3, 48'h5000, 1'b0, 1'b1);
    step();
    check("rs_owner_pre", 64'(owner), 64'd3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    check_quiet("rs_after");
    check("rs_owner_zero", 64'(owner), 64'd0);
    step();
    check("rs_rearb_owner", 64'(owner), 64'd0);
    check("rs_rearb_busy", 64'(busy), 64'd1);
    mst_rsp = '{rdata: 32'h0, error: 1'b0, ready: 1'b1};
    #1;
    check("rs_ready", 64'(slv_rsp[0].ready), 64'd1);
    step();
    slv_req = '0;
    mst_rsp = '0;
    #1;
    check("rs_idle", 64'(busy), 64'd0);

    // Ready arrives in BUSY cycle 8: completion beats the watchdog
    set_req(3, 48'h3000, 1'b0, 1'b1);
    for (int b = 1; b <= 7; b++) begin
      step();
      check("bd_busy", 64'(busy), 64'd1);
      check("bd_owner", 64'(owner), 64'd3);
    end
    step();
    mst_rsp = '{rdata: 32'hCAFEF00D, error: 1'b0, ready: 1'b1};
    #1;
    check("bd_ready", 64'(slv_rsp[3].ready), 64'd1);
    check("bd_error", 64'(slv_rsp[3].error), 64'd0);
    check("bd_rdata", 64'(slv_rsp[3].rdata), 64'hCAFEF00D);
    check("bd_tout", 64'(tout), 64'd0);
    step();
    slv_req = '0;
    mst_rsp = '0;
    #1;
    check_quiet("bd_after");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/cheshire_regbus_arbiter.md
Name: cheshire_regbus_arbiter

Overview:
- Shares the single Regbus demux input (RegbusInXbar, reg_a48_d32 types) between NumReq requesters, e.g. the AXI-to-Regbus bridge plus a debug/boot sequencer.
- Round-robin arbitration with a registered grant; the granted request is locked until its handshake completes.
- A watchdog aborts transactions that are never acknowledged and returns an error to the owner.
- Sits between the requesters and the Regbus demux.

Parameters:
- NumReq, 2, number of requester ports; must be ≥2.
- TimeoutCycles, 1024, BUSY cycles before abort; 0 disables the watchdog.
- ErrData, 32'hBADCAB1E, rdata returned on a timeout abort.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous reset, active-high.
- slv_req_i  in  NumReq x reg_a48_d32_req_t  requester requests (addr, write, wdata, wstrb, valid).
- slv_rsp_o  out  NumReq x reg_a48_d32_rsp_t  requester responses (rdata, error, ready).
- mst_req_o  out  reg_a48_d32_req_t  request to the Regbus demux.
- mst_rsp_i  in  reg_a48_d32_rsp_t  response from the Regbus demux.
- busy_o  out  1  high in BUSY and ABORT.
- owner_o  out  $clog2(NumReq)  current owner index; valid while busy_o is high.
- timeout_o  out  1  one-cycle pulse on a watchdog abort.

Behaviour:
- Regbus handshake: a transaction completes in the cycle where valid && ready. Requesters hold the request stable until then.
- State machine IDLE, BUSY, ABORT. Reset values:
  - state=IDLE, owner=0, rr_ptr=0, cnt=0.
  - All outputs zero: mst_req_o='0, slv_rsp_o='0, busy_o=0, owner_o=0, timeout_o=0.
- IDLE:
  - mst_req_o.valid=0 and every slv_rsp_o is zero.
  - If any slv_req_i[i].valid is high: pick the first valid index scanning rr_ptr, rr_ptr+1, … modulo NumReq. Register it as owner, clear cnt, go to BUSY.
  - Arbitration costs exactly one cycle; there is no combinational path from slv valid to mst valid.
- BUSY:
  - mst_req_o = slv_req_i[owner] (combinational passthrough).
  - slv_rsp_o[owner] = mst_rsp_i; all other slv_rsp_o stay '0 (ready=0).
  - Completion (slv_req_i[owner].valid && mst_rsp_i.ready): rr_ptr <= (owner+1) mod NumReq, go to IDLE. Minimum spacing is therefore 2 cycles per transaction.
  - Owner drops valid without a handshake (protocol violation): go to IDLE, rr_ptr <= owner+1, no error reported.
  - cnt increments each BUSY cycle without completion and saturates. If TimeoutCycles≠0 and cnt==TimeoutCycles-1 without completion: go to ABORT.
  - Completion wins over timeout in the same cycle.
- ABORT (one cycle):
  - mst_req_o.valid=0.
  - slv_rsp_o[owner] = {rdata:ErrData, error:1, ready:1}.
  - timeout_o=1; rr_ptr <= owner+1; next state IDLE.
- Requests on non-owner ports wait, unacknowledged, with no loss.
- A new requester can never preempt the owner.
- Simultaneous valids: the rr_ptr order guarantees each requester is granted within NumReq grants.
- rst_i asserted mid-transaction: the next cycle is IDLE with all outputs zero. The pending owner gets no response and must re-issue.
- Counter width $clog2(TimeoutCycles+1). rr_ptr and owner wrap from NumReq-1 to 0.

Decomposition:
- cheshire_pkg gains:
  - enum regbus_arb_inputs_e {RegbusArbInXbar, RegbusArbInDbg, RegbusArbNumInputs}.
  - localparam RegbusArbTimeout = 1024.
  - Reuses reg_a48_d32_req_t / reg_a48_d32_rsp_t.
- The FSM enum is local to the module.
- Sub-module cheshire_rr_picker: combinational first-valid-from-pointer search (inputs valid vector and rr_ptr; outputs index and any). It is unit-testable on its own.

Test Plan:
- Single read: req0 valid, addr 48'h02000000, demux ready after 3 cycles with rdata 32'h12345678. Expect:
  - mst valid rises one cycle after slv valid.
  - slv_rsp_o[0] carries ready=1 and rdata=32'h12345678 in the handshake cycle.
  - IDLE on the next cycle, rr_ptr=1.
- Contention: req0 and req1 held valid continuously with demux ready=1. Expect grants alternating 0,1,0,1 and a handshake every 2 cycles; the non-owner's ready stays 0.
- Fairness with NumReq=4: all four valid from reset. Expect grant order 0,1,2,3,0; no requester waits more than 4 grants.
- Timeout with TimeoutCycles=8: demux never ready on a write to 48'h10000000. Expect:
  - ABORT after 8 BUSY cycles.
  - slv_rsp_o[owner] = {ready:1, error:1, rdata:32'hBADCAB1E}, timeout_o pulses for 1 cycle, mst valid low in that cycle.
- Completion at the timeout boundary: ready arrives in BUSY cycle 8 with TimeoutCycles=8. Expect normal completion, error=0, timeout_o=0.
- Reset mid-transaction: rst_i=1 for 1 cycle during BUSY. Expect:
  - Next cycle all outputs zero, busy_o=0.
  - A request still valid is re-arbitrated from rr_ptr=0.
